// File: rtl/mem_if_pkg.sv
// mem_if_pkg: shared RAM geometry defaults and the access controller FSM states.
package mem_if_pkg;
    localparam int MEM_WIDTH_DEF = 16;
    localparam int MEM_DEPTH_DEF = 256;
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;
endpackage

// File: rtl/mem_access_ctrl_if.sv
// mem_access_ctrl_if: CPU request/response handshake plus RAM control and read bus.
interface mem_access_ctrl_if
    import mem_if_pkg::*;
#(
    parameter int MEM_WIDTH  = MEM_WIDTH_DEF,
    parameter int ADDR_WIDTH = $clog2(MEM_DEPTH_DEF)
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [MEM_WIDTH-1:0]  req_wdata;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [MEM_WIDTH-1:0]  rsp_rdata;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic                  ram_r_en;
    logic                  ram_w_en;
    logic [MEM_WIDTH-1:0]  ram_write_data;
    logic [MEM_WIDTH-1:0]  MDR_RAM_connect;
    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, rsp_ready, MDR_RAM_connect,
        output req_ready, rsp_valid, rsp_rdata, ram_addr, ram_r_en, ram_w_en, ram_write_data
    );
    modport master (
        output req_valid, req_we, req_addr, req_wdata, rsp_ready, MDR_RAM_connect,
        input  req_ready, rsp_valid, rsp_rdata, ram_addr, ram_r_en, ram_w_en, ram_write_data
    );
endinterface

// File: rtl/mem_wait_counter.sv
// mem_wait_counter: loadable 4-bit down-counter that parks at zero and flags it.
module mem_wait_counter (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_load,
    input  logic       i_en,
    input  logic [3:0] i_load_val,
    output logic       o_zero
);
    logic [3:0] r_cnt;
    always_ff @(posedge clk) begin
        if (rst)
            r_cnt <= '0;
        else if (i_load)
            r_cnt <= i_load_val;
        else if (i_en && r_cnt != '0)
            r_cnt <= r_cnt - 4'd1;
    end
    assign o_zero = (r_cnt == '0);
endmodule

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: holds MAR/MDR and turns single-beat CPU loads/stores into RAM
// strobes, with WAIT_CYCLES extra access cycles and a valid/ready response.
module mem_access_ctrl
    import mem_if_pkg::*;
#(
    parameter int MEM_WIDTH   = MEM_WIDTH_DEF,
    parameter int MEM_DEPTH   = MEM_DEPTH_DEF,
    parameter int WAIT_CYCLES = 0
) (
    input logic              clk,
    input logic              rst,
    mem_access_ctrl_if.slave bus
);
    localparam int ADDR_WIDTH = $clog2(MEM_DEPTH);

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_mar;
    logic [MEM_WIDTH-1:0]  r_mdr;
    logic                  r_we;
    logic                  r_ren;
    logic                  r_rsp_valid;
    logic                  r_req_ready;
    logic                  w_zero;
    logic                  w_accept;
    logic                  w_in_access;

    assign w_accept    = (r_state == ST_IDLE) && bus.req_valid;
    assign w_in_access = (r_state == ST_ACCESS);

    mem_wait_counter u_wait (
        .clk       (clk),
        .rst       (rst),
        .i_load    (w_accept),
        .i_en      (w_in_access),
        .i_load_val(4'(WAIT_CYCLES)),
        .o_zero    (w_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_mar       <= '0;
            r_mdr       <= '0;
            r_we        <= 1'b0;
            r_ren       <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_req_ready <= 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: if (bus.req_valid) begin
                    r_mar       <= bus.req_addr;
                    r_mdr       <= bus.req_wdata;
                    r_we        <= bus.req_we;
                    r_ren       <= ~bus.req_we;
                    r_req_ready <= 1'b0;
                    r_state     <= ST_ACCESS;
                end
                ST_ACCESS: if (w_zero) begin
                    r_mdr       <= r_we ? r_mdr : bus.MDR_RAM_connect;
                    r_ren       <= 1'b0;
                    r_rsp_valid <= 1'b1;
                    r_state     <= ST_RESP;
                end
                ST_RESP: if (bus.rsp_ready) begin
                    r_rsp_valid <= 1'b0;
                    r_req_ready <= 1'b1;
                    r_state     <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // rst gates the write strobe so a reset landing on the completing cycle never writes
    assign bus.ram_w_en       = w_in_access && r_we && w_zero && !rst;
    assign bus.ram_r_en       = r_ren;
    assign bus.req_ready      = r_req_ready && !rst;
    assign bus.rsp_valid      = r_rsp_valid;
    assign bus.rsp_rdata      = r_mdr;
    assign bus.ram_addr       = r_mar;
    assign bus.ram_write_data = r_mdr;
endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: three controllers (WAIT_CYCLES 0/3/2) on RAM models, scoreboard-checked.
module tb_mem_access_ctrl;
    import mem_if_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst       [3];
    logic        req_valid [3];
    logic        req_we    [3];
    logic [7:0]  req_addr  [3];
    logic [15:0] req_wdata [3];
    logic        rsp_ready [3];
    logic        req_ready [3];
    logic        rsp_valid [3];
    logic [15:0] rsp_rdata [3];
    logic [7:0]  ram_addr  [3];
    logic        ram_r_en  [3];
    logic        ram_w_en  [3];
    logic [15:0] ram_wdata [3];
    state_t      st        [3];

    int          wen_cnt  [3];
    int          ren_cnt  [3];
    logic [7:0]  wen_addr [3];
    logic [15:0] exp_q    [3][$];
    int passed = 0;
    int total  = 0;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        mem_access_ctrl_if #(.MEM_WIDTH(16), .ADDR_WIDTH(8)) bus ();
        logic [15:0] mem [256];
        assign bus.req_valid       = req_valid[g];
        assign bus.req_we          = req_we[g];
        assign bus.req_addr        = req_addr[g];
        assign bus.req_wdata       = req_wdata[g];
        assign bus.rsp_ready       = rsp_ready[g];
        assign bus.MDR_RAM_connect = bus.ram_r_en ? mem[bus.ram_addr] : 16'hDEAD;
        assign req_ready[g]        = bus.req_ready;
        assign rsp_valid[g]        = bus.rsp_valid;
        assign rsp_rdata[g]        = bus.rsp_rdata;
        assign ram_addr[g]         = bus.ram_addr;
        assign ram_r_en[g]         = bus.ram_r_en;
        assign ram_w_en[g]         = bus.ram_w_en;
        assign ram_wdata[g]        = bus.ram_write_data;
        assign st[g]               = dut.r_state;
        mem_access_ctrl #(
            .MEM_WIDTH  (16),
            .MEM_DEPTH  (256),
            .WAIT_CYCLES(g == 0 ? 0 : g == 1 ? 3 : 2)
        ) dut (
            .clk(clk),
            .rst(rst[g]),
            .bus(bus)
        );
        always @(posedge clk) if (bus.ram_w_en) mem[bus.ram_addr] <= bus.ram_write_data;
    end

    function automatic int wc(int k);
        return k == 0 ? 0 : k == 1 ? 3 : 2;
    endfunction

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endfunction

    // monitor: invariants every cycle, scoreboard pop on each response handshake
    always @(negedge clk) begin
        #1;
        for (int k = 0; k < 3; k++) begin
            chk("rw_exclusive", 32'(ram_r_en[k] & ram_w_en[k]), 0);
            if (st[k] != ST_ACCESS) chk("ren_outside_access", 32'(ram_r_en[k]), 0);
            if (ram_w_en[k]) begin
                wen_cnt[k]++;
                wen_addr[k] = ram_addr[k];
            end
            if (ram_r_en[k]) ren_cnt[k]++;
            if (rsp_valid[k] && rsp_ready[k]) begin
                if (exp_q[k].size() == 0) chk("rsp_unexpected", 1, 0);
                else chk("rsp_rdata", 32'(rsp_rdata[k]), 32'(exp_q[k].pop_front()));
            end
        end
    end

    task automatic accept(int k, logic we, logic [7:0] a, logic [15:0] d);
        int n = 0;
        @(negedge clk);
        req_valid[k] = 1'b1;
        req_we[k]    = we;
        req_addr[k]  = a;
        req_wdata[k] = d;
        while (!req_ready[k] && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("accept_timeout", 1, 0);
        @(posedge clk);
        @(negedge clk);
        req_valid[k] = 1'b0;
    endtask

    task automatic wait_rsp(int k, output int e);
        e = 0;
        while (!rsp_valid[k] && e < 50) begin
            @(posedge clk);
            e++;
            @(negedge clk);
        end
        if (e >= 50) chk("rsp_timeout", 1, 0);
    endtask

    task automatic xfer(int k, logic we, logic [7:0] a, logic [15:0] d, logic [15:0] exp);
        int e;
        exp_q[k].push_back(exp);
        accept(k, we, a, d);
        wait_rsp(k, e);
        chk("latency", e, wc(k) + 1);
        @(posedge clk);
        @(negedge clk);
        #2 chk("rsp_dropped_after_hs", 32'(rsp_valid[k]), 0);
    endtask

    task automatic reset_values(int k);
        chk("rst_req_ready", 32'(req_ready[k]), 0);
        chk("rst_rsp_valid", 32'(rsp_valid[k]), 0);
        chk("rst_r_en", 32'(ram_r_en[k]), 0);
        chk("rst_w_en", 32'(ram_w_en[k]), 0);
        chk("rst_mar", 32'(ram_addr[k]), 0);
        chk("rst_mdr", 32'(ram_wdata[k]), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        int w0, r0, e;
        for (int k = 0; k < 3; k++) begin
            rst[k] = 1'b1; req_valid[k] = 1'b0; req_we[k] = 1'b0;
            req_addr[k] = '0; req_wdata[k] = '0; rsp_ready[k] = 1'b1;
            wen_cnt[k] = 0; ren_cnt[k] = 0; wen_addr[k] = '0;
        end
        @(negedge clk);
        @(negedge clk);
        #2 for (int k = 0; k < 3; k++) reset_values(k);
        @(negedge clk);
        for (int k = 0; k < 3; k++) rst[k] = 1'b0;
        #2 for (int k = 0; k < 3; k++) chk("idle_req_ready", 32'(req_ready[k]), 1);

        // WAIT_CYCLES = 0: store/load, boundary address
        w0 = wen_cnt[0];
        xfer(0, 1'b1, 8'h10, 16'hBEEF, 16'hBEEF);
        chk("store_pulse_count", wen_cnt[0] - w0, 1);
        chk("store_pulse_addr", 32'(wen_addr[0]), 32'h10);
        xfer(0, 1'b0, 8'h10, 16'h0000, 16'hBEEF);
        xfer(0, 1'b1, 8'h00, 16'h5555, 16'h5555);
        xfer(0, 1'b1, 8'hFF, 16'hCAFE, 16'hCAFE);
        xfer(0, 1'b0, 8'hFF, 16'h0000, 16'hCAFE);
        xfer(0, 1'b0, 8'h00, 16'h0000, 16'h5555);

        // backpressure with a second request held pending
        xfer(0, 1'b1, 8'h40, 16'hA5A5, 16'hA5A5);
        exp_q[0].push_back(16'hA5A5);
        rsp_ready[0] = 1'b0;
        accept(0, 1'b0, 8'h40, 16'h0000);
        wait_rsp(0, e);
        exp_q[0].push_back(16'hBEEF);
        req_valid[0] = 1'b1; req_we[0] = 1'b0; req_addr[0] = 8'h10;
        repeat (6) begin
            #2;
            chk("hold_valid", 32'(rsp_valid[0]), 1);
            chk("hold_rdata", 32'(rsp_rdata[0]), 32'hA5A5);
            chk("hold_req_ready", 32'(req_ready[0]), 0);
            chk("hold_mar", 32'(ram_addr[0]), 32'h40);
            @(negedge clk);
        end
        rsp_ready[0] = 1'b1;
        @(negedge clk);
        #2 chk("post_hs_req_ready", 32'(req_ready[0]), 1);
        chk("post_hs_rsp_valid", 32'(rsp_valid[0]), 0);
        @(posedge clk);
        @(negedge clk);
        req_valid[0] = 1'b0;
        #2 chk("second_accepted", 32'(req_ready[0]), 0);
        wait_rsp(0, e);
        chk("second_latency", e, 1);
        @(posedge clk);
        @(negedge clk);

        // WAIT_CYCLES = 3: read enable spans every access cycle
        xfer(1, 1'b1, 8'h05, 16'h1234, 16'h1234);
        r0 = ren_cnt[1];
        w0 = wen_cnt[1];
        xfer(1, 1'b0, 8'h05, 16'h0000, 16'h1234);
        chk("ren_cycles", ren_cnt[1] - r0, 4);
        chk("load_no_wen", wen_cnt[1] - w0, 0);

        // WAIT_CYCLES = 2: reset in the 2nd and in the completing access cycle
        xfer(2, 1'b1, 8'h20, 16'h0001, 16'h0001);
        w0 = wen_cnt[2];
        accept(2, 1'b1, 8'h20, 16'hFFFF);
        @(negedge clk);
        rst[2] = 1'b1;
        @(negedge clk);
        #2 reset_values(2);
        @(negedge clk);
        rst[2] = 1'b0;
        accept(2, 1'b1, 8'h20, 16'hFFFF);
        @(negedge clk);
        @(negedge clk);
        rst[2] = 1'b1;
        #2 chk("rst_gates_wen", 32'(ram_w_en[2]), 0);
        @(negedge clk);
        rst[2] = 1'b0;
        @(negedge clk);
        chk("rst_no_write", wen_cnt[2] - w0, 0);
        xfer(2, 1'b0, 8'h20, 16'h0000, 16'h0001);

        @(negedge clk);
        @(negedge clk);
        for (int k = 0; k < 3; k++) chk("scoreboard_drained", exp_q[k].size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
